// File: rtl/key_pkg.sv
// Shared definitions for the key debounce block: FSM state encoding,
// default timing constants and counter sizing helpers.
// Optional feature macro used by the design: KEY_REPEAT_EN (auto-repeat).
package key_pkg;

  // Default timing in 1 kHz clock cycles
  localparam int DEB_CYC_DEF = 20;
  localparam int RPT_DLY_DEF = 500;
  localparam int RPT_PER_DEF = 200;

  // Counters are never narrower than this, whatever the timing parameters
  localparam int CNT_MIN_W = 10;

  // Per-channel FSM state, 2-bit encoding kept as plain constants
  typedef logic [1:0] key_state_t;
  localparam key_state_t ST_IDLE      = 2'b00;
  localparam key_state_t ST_PRESS_CHK = 2'b01;
  localparam key_state_t ST_HELD      = 2'b10;
  localparam key_state_t ST_REL_CHK   = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width needed to count up to maxVal, floored at CNT_MIN_W
  function automatic int cnt_width(input int maxVal);
    int w;
    w = $clog2(maxVal + 1);
    return (w < CNT_MIN_W) ? CNT_MIN_W : w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM with a saturating
// counter, registered press pulse and held level.
// Optional feature macro: KEY_REPEAT_EN adds an auto-repeat timer in HELD.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF,
  parameter int RPT_DLY = RPT_DLY_DEF,
  parameter int RPT_PER = RPT_PER_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic pulse_o,
  output logic level_o
);

  // One width covers every counter in the channel so the debounce and
  // repeat counters can both reach their longest interval
  localparam int CNT_W = cnt_width(max_int(DEB_CYC, max_int(RPT_DLY, RPT_PER)));
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

  logic             sync1_q;
  logic             sync2_q;
  key_state_t       state_q;
  key_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             pulse_q;
  logic             pulse_d;
  logic             press_fire;

  // Two-flop synchronizer for the asynchronous raw key level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM: a level change is accepted only after DEB_CYC stable samples
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    press_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sync2_q) begin
          state_d = ST_PRESS_CHK;
        end
      end
      ST_PRESS_CHK: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LAST) begin
          state_d    = ST_HELD;
          cnt_d      = '0;
          level_d    = 1'b1;
          press_fire = 1'b1;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        cnt_d = '0;
        if (!sync2_q) begin
          state_d = ST_REL_CHK;
        end
      end
      ST_REL_CHK: begin
        if (sync2_q) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(RPT_DLY - 1);
  localparam logic [CNT_W-1:0] RPT_PER_LAST = CNT_W'(RPT_PER - 1);

  logic [CNT_W-1:0] rpt_q;
  logic [CNT_W-1:0] rpt_d;
  logic             rpt_first_q;
  logic             rpt_first_d;
  logic             rpt_fire;

  // Repeat timer: runs only while held high in HELD, restarts at the long delay otherwise
  always_comb begin
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    if (state_q == ST_HELD && sync2_q) begin
      if (rpt_q >= (rpt_first_q ? RPT_DLY_LAST : RPT_PER_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_d       = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_d = (rpt_q == CNT_MAX) ? rpt_q : rpt_q + CNT_ONE;
      end
    end else begin
      rpt_d       = '0;
      rpt_first_d = 1'b1;
    end
  end

  // Repeat timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  assign pulse_d = press_fire | rpt_fire;
`else
  assign pulse_d = press_fire;
`endif

  // FSM state, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign level_o = level_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: N_KEY independent channels, each producing a
// one-cycle press pulse (ANJIAN) and a debounced held level.
// Optional feature macro: KEY_REPEAT_EN enables auto-repeat pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int N_KEY   = 5,
  parameter int DEB_CYC = DEB_CYC_DEF,
  parameter int RPT_DLY = RPT_DLY_DEF,
  parameter int RPT_PER = RPT_PER_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_KEY-1:0] key_raw,
  output logic [N_KEY-1:0] ANJIAN,
  output logic [N_KEY-1:0] key_level
);

  for (genvar g = 0; g < N_KEY; g++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYC (DEB_CYC),
      .RPT_DLY (RPT_DLY),
      .RPT_PER (RPT_PER)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (key_raw[g]),
      .pulse_o (ANJIAN[g]),
      .level_o (key_level[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with a run-length reference model.
// Honours KEY_REPEAT_EN when defined (adds the auto-repeat scenario).
module tb_key_debounce;
  import key_pkg::*;

  localparam int NK  = 5;
  localparam int DEB = DEB_CYC_DEF;
  localparam int RD  = RPT_DLY_DEF;
  localparam int RP  = RPT_PER_DEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_raw = '0;
  logic [NK-1:0] ANJIAN;
  logic [NK-1:0] key_level;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Reference model state, per channel
  bit pipe1 [NK];
  bit pipe2 [NK];
  bit mLevel[NK];
  bit mPulse[NK];
  int onesRun [NK];
  int zerosRun[NK];
  int ageCnt  [NK];

  int pulseCount[NK];
  int rptTimes[$];
  bit levelDrop;

  always #5 clk = ~clk;

  key_debounce #(
    .N_KEY   (NK),
    .DEB_CYC (DEB),
    .RPT_DLY (RD),
    .RPT_PER (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .ANJIAN    (ANJIAN),
    .key_level (key_level)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Model: a press is accepted after DEB+1 synced ones in a row, a release after DEB+1 zeros
  task automatic modelStep(input logic r, input logic [NK-1:0] raw);
    bit s;
    for (int c = 0; c < NK; c++) begin
      if (r) begin
        pipe1[c] = 0; pipe2[c] = 0; mLevel[c] = 0; mPulse[c] = 0;
        onesRun[c] = 0; zerosRun[c] = 0; ageCnt[c] = 0;
      end else begin
        s = pipe2[c];
        pipe2[c] = pipe1[c];
        pipe1[c] = raw[c];
        mPulse[c] = 0;
        if (s) begin onesRun[c]++; zerosRun[c] = 0; end
        else   begin zerosRun[c]++; onesRun[c] = 0; end
        if (!mLevel[c]) begin
          if (onesRun[c] == DEB + 1) begin
            mLevel[c] = 1; mPulse[c] = 1; ageCnt[c] = 0;
          end
        end else if (s) begin
          if (onesRun[c] == 1) ageCnt[c] = 0;
          else begin
            ageCnt[c]++;
`ifdef KEY_REPEAT_EN
            if (ageCnt[c] == RD || (ageCnt[c] > RD && (ageCnt[c] - RD) % RP == 0)) mPulse[c] = 1;
`endif
          end
        end else if (zerosRun[c] == DEB + 1) begin
          mLevel[c] = 0;
        end
      end
    end
  endtask

  // One clock cycle: drive, clock, then compare DUT against the model
  task automatic applyStimulus(input logic r, input logic [NK-1:0] raw);
    logic [NK-1:0] expP;
    logic [NK-1:0] expL;
    rst = r;
    key_raw = raw;
    @(posedge clk);
    #1;
    modelStep(r, raw);
    for (int c = 0; c < NK; c++) begin
      expP[c] = mPulse[c];
      expL[c] = mLevel[c];
      if (ANJIAN[c] === 1'b1) pulseCount[c]++;
    end
    checkOutput("ANJIAN_model", ANJIAN, expP);
    checkOutput("key_level_model", key_level, expL);
    cyc++;
  endtask

  task automatic resetDut(input int n, input logic [NK-1:0] raw);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, raw);
      checkOutput("rst_ANJIAN", ANJIAN, '0);
      checkOutput("rst_key_level", key_level, '0);
    end
    for (int c = 0; c < NK; c++) pulseCount[c] = 0;
  endtask

  initial begin
    logic [NK-1:0] v;

    // Scenario 1: raw[2] rises at cycle 10 -> pulse at 32
    resetDut(2, '0);
    for (int n = 0; n < 60; n++) begin
      applyStimulus(1'b0, (n >= 10) ? 5'b00100 : 5'b00000);
      if (n == 31) checkOutput("s1_no_pulse_31", ANJIAN, 5'b00000);
      if (n == 32) begin
        checkOutput("s1_pulse_32", ANJIAN, 5'b00100);
        checkOutput("s1_level_32", key_level, 5'b00100);
      end
    end
    checkOutput("s1_pulse_count", pulseCount[2], 1);

    // Scenario 2: bounce on raw[3], stable from 100 -> one pulse at 122
    resetDut(2, '0);
    for (int n = 0; n < 150; n++) begin
      v = '0;
      v[3] = (n >= 80 && n < 85) || (n >= 90 && n < 95) || (n >= 100);
      applyStimulus(1'b0, v);
      if (n == 99)  checkOutput("s2_level_bounce", key_level, 5'b00000);
      if (n == 121) checkOutput("s2_no_pulse_121", ANJIAN, 5'b00000);
      if (n == 122) checkOutput("s2_pulse_122", ANJIAN, 5'b01000);
    end
    checkOutput("s2_pulse_count", pulseCount[3], 1);

    // Scenario 3: raw[2] and raw[4] together from cycle 0 -> both pulse at 22
    resetDut(2, '0);
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'b0, 5'b10100);
      if (n == 22) checkOutput("s3_pulse_22", ANJIAN, 5'b10100);
    end
    checkOutput("s3_other_bits", pulseCount[0] + pulseCount[1] + pulseCount[3], 0);
    checkOutput("s3_bit4_count", pulseCount[4], 1);

    // Scenario 4: held 40, low 10, high again -> single pulse, level never drops
    resetDut(2, '0);
    levelDrop = 0;
    for (int n = 0; n < 120; n++) begin
      applyStimulus(1'b0, (n < 40 || n >= 50) ? 5'b00010 : 5'b00000);
      if (n >= 22 && key_level[1] !== 1'b1) levelDrop = 1;
    end
    checkOutput("s4_pulse_count", pulseCount[1], 1);
    checkOutput("s4_level_held", levelDrop, 0);

    // Scenario 5: reset while raw[0] is in HELD -> re-debounce, pulse 22 after rst falls
    resetDut(2, '0);
    for (int n = 0; n < 40; n++) applyStimulus(1'b0, 5'b00001);
    resetDut(3, 5'b00001);
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'b0, 5'b00001);
      if (n == 21) checkOutput("s5_no_pulse_21", ANJIAN, 5'b00000);
      if (n == 22) checkOutput("s5_pulse_22", ANJIAN, 5'b00001);
    end
    checkOutput("s5_pulse_count", pulseCount[0], 1);

`ifdef KEY_REPEAT_EN
    // Scenario 6: held 1000 cycles after the press pulse -> 22, 522, 722, 922
    resetDut(2, '0);
    for (int n = 0; n < 1082; n++) begin
      applyStimulus(1'b0, (n < 1022) ? 5'b00001 : 5'b00000);
      if (ANJIAN[0] === 1'b1) rptTimes.push_back(n);
    end
    checkOutput("s6_rpt_count", rptTimes.size(), 4);
    if (rptTimes.size() == 4) begin
      checkOutput("s6_rpt_0", rptTimes[0], 22);
      checkOutput("s6_rpt_1", rptTimes[1], 522);
      checkOutput("s6_rpt_2", rptTimes[2], 722);
      checkOutput("s6_rpt_3", rptTimes[3], 922);
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
